// File: rtl/dmem_arbiter.sv
// dmem_arbiter: arbiter and read sequencer sharing one data memory between the core (C) and an external port (E)
// Ports: clk, reset (synchronous, active-high)
//   c_req/c_we/c_mode/c_addr/c_wdata in, c_gnt/c_rvalid/c_rdata out: core load/store port
//   e_req/e_we/e_mode/e_addr/e_wdata in, e_gnt/e_rvalid/e_rdata out: external loader/debug port
//   core_stall out: freezes core PC/register write
//   m_en/m_we/m_mode/m_addr/m_wdata out, m_rdata in: memory pins (read data valid the cycle after the strobe)
// Build option: DMEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration; otherwise port C has fixed priority.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [3:0]        c_mode,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  output logic              core_stall,
  input  logic              e_req,
  input  logic              e_we,
  input  logic [3:0]        e_mode,
  input  logic [ADDR_W-1:0] e_addr,
  input  logic [DATA_W-1:0] e_wdata,
  output logic              e_gnt,
  output logic              e_rvalid,
  output logic [DATA_W-1:0] e_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [3:0]        m_mode,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);
  typedef enum logic [1:0] {IDLE, RD_C, RD_E} state_e;
  state_e state_q, state_d;
  logic idle, pick_c;
  assign idle = (state_q == IDLE) && !reset;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic rr_q;
  assign pick_c = c_req && (!e_req || !rr_q);
  always_ff @(posedge clk) rr_q <= reset ? 1'b0 : rr_q ^ m_en;
`else
  assign pick_c = c_req;
`endif
  always_comb begin
    c_gnt = idle && pick_c;
    e_gnt = idle && e_req && !pick_c;
    m_en = c_gnt || e_gnt;
    m_we = c_gnt ? c_we : e_gnt ? e_we : 1'b0;
    m_mode = c_gnt ? c_mode : e_gnt ? e_mode : '0;
    m_addr = c_gnt ? c_addr : e_gnt ? e_addr : '0;
    m_wdata = c_gnt ? c_wdata : e_gnt ? e_wdata : '0;
    c_rvalid = state_q == RD_C;
    e_rvalid = state_q == RD_E;
    c_rdata = c_rvalid ? m_rdata : '0;
    e_rdata = e_rvalid ? m_rdata : '0;
    // a load holds the core through its grant cycle and retires in RD_C
    core_stall = !reset && ((c_req && !c_gnt) || (c_gnt && !c_we));
    state_d = (c_gnt && !c_we) ? RD_C : (e_gnt && !e_we) ? RD_E : IDLE;
  end
  always_ff @(posedge clk) state_q <= reset ? IDLE : state_d;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter against a cycle-level reference model
module tb_dmem_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  logic c_req = 0, c_we = 0, e_req = 0, e_we = 0;
  logic [3:0] c_mode = 0, e_mode = 0, m_mode;
  logic [31:0] c_addr = 0, c_wdata = 0, e_addr = 0, e_wdata = 0;
  logic c_gnt, c_rvalid, e_gnt, e_rvalid, core_stall, m_en, m_we;
  logic [31:0] c_rdata, e_rdata, m_addr, m_wdata, m_rdata = 0;
  always #5 clk = ~clk;
  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_mode(c_mode), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .core_stall(core_stall),
    .e_req(e_req), .e_we(e_we), .e_mode(e_mode), .e_addr(e_addr), .e_wdata(e_wdata),
    .e_gnt(e_gnt), .e_rvalid(e_rvalid), .e_rdata(e_rdata),
    .m_en(m_en), .m_we(m_we), .m_mode(m_mode), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );
  logic [31:0] tmem [16];
  always @(posedge clk)
    if (m_en) begin
      if (m_we) tmem[m_addr[5:2]] <= m_wdata;
      else m_rdata <= tmem[m_addr[5:2]];
    end
  typedef struct {
    logic cg, eg, crv, erv, stall, men, mwe;
    logic [31:0] crd, erd, madr, mwd;
    logic [3:0] mmode;
  } exp_t;
  exp_t q[$];
  int checks = 0, passed = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a === e) passed++;
    else $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", n, $time, a, e);
  endtask
  initial forever begin
    exp_t x;
    @(negedge clk);
    if (q.size() > 0) begin
      x = q.pop_front();
      chk("c_gnt", 32'(c_gnt), 32'(x.cg));
      chk("e_gnt", 32'(e_gnt), 32'(x.eg));
      chk("c_rvalid", 32'(c_rvalid), 32'(x.crv));
      chk("e_rvalid", 32'(e_rvalid), 32'(x.erv));
      chk("c_rdata", c_rdata, x.crd);
      chk("e_rdata", e_rdata, x.erd);
      chk("core_stall", 32'(core_stall), 32'(x.stall));
      chk("m_en", 32'(m_en), 32'(x.men));
      chk("m_we", 32'(m_we), 32'(x.mwe));
      if (x.men) begin
        chk("m_addr", m_addr, x.madr);
        chk("m_wdata", m_wdata, x.mwd);
        chk("m_mode", 32'(m_mode), 32'(x.mmode));
      end
    end
  end
  // reference model: memory contents, the outstanding read (0 none, 1 C, 2 E), preferred port (0 C, 1 E)
  logic [31:0] mmem [16];
  int pend = 0, pidx = 0;
  bit ptr = 0;
  logic c_r = 0, c_w = 0, e_r = 0, e_w = 0, rst_v = 0;
  logic [3:0] c_m = 0, e_m = 0;
  logic [31:0] c_a = 0, c_d = 0, e_a = 0, e_d = 0;
  task automatic tick();
    exp_t x = '{default: '0};
    int win = 0;
    logic [31:0] a, d;
    reset = rst_v;
    c_req = c_r; c_we = c_w; c_mode = c_m; c_addr = c_a; c_wdata = c_d;
    e_req = e_r; e_we = e_w; e_mode = e_m; e_addr = e_a; e_wdata = e_d;
    if (pend == 1) begin x.crv = 1; x.crd = mmem[pidx]; end
    if (pend == 2) begin x.erv = 1; x.erd = mmem[pidx]; end
    if (rst_v) begin
      pend = 0;
      ptr = 0;
    end else if (pend != 0) begin
      x.stall = c_r;
      pend = 0;
    end else begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      if (c_r && e_r) win = ptr ? 2 : 1;
`else
      if (c_r && e_r) win = 1;
`endif
      else if (c_r) win = 1;
      else if (e_r) win = 2;
      if (win != 0) begin
        a = (win == 1) ? c_a : e_a;
        d = (win == 1) ? c_d : e_d;
        x.men = 1;
        x.mwe = (win == 1) ? c_w : e_w;
        x.madr = a;
        x.mwd = d;
        x.mmode = (win == 1) ? c_m : e_m;
        if (x.mwe) mmem[a[5:2]] = d;
        else begin pend = win; pidx = int'(a[5:2]); end
        ptr = !ptr;
      end
      x.cg = win == 1;
      x.eg = win == 2;
      x.stall = c_r && (win != 1 || !c_w);
    end
    q.push_back(x);
    @(posedge clk);
    #1;
    if (x.cg) c_r = 0;
    if (x.eg) e_r = 0;
  endtask
  task automatic set_c(input logic w, input logic [31:0] a, input logic [31:0] d);
    c_r = 1; c_w = w; c_a = a; c_d = d; c_m = 4'($urandom);
  endtask
  task automatic set_e(input logic w, input logic [31:0] a, input logic [31:0] d);
    e_r = 1; e_w = w; e_a = a; e_d = d; e_m = 4'($urandom);
  endtask
  initial begin
    for (int i = 0; i < 16; i++) begin
      tmem[i] = 32'h0101_0101 * 32'(i);
      mmem[i] = 32'h0101_0101 * 32'(i);
    end
    @(posedge clk);
    #1;
    rst_v = 1; tick(); rst_v = 0;
    // core write then read-back
    set_c(1, 32'h10, 32'hDEADBEEF); tick();
    set_c(0, 32'h10, 0); tick();
    tick(); tick();
    // simultaneous reads after reset
    rst_v = 1; tick(); rst_v = 0;
    set_c(0, 32'h20, 0); set_e(0, 32'h24, 0);
    for (int i = 0; i < 6; i++) tick();
    // core back-to-back writes while E waits
    set_e(0, 32'h08, 0);
    for (int i = 0; i < 3; i++) begin set_c(1, 32'(4 * (i + 1)), $urandom); tick(); end
    c_r = 0;
    for (int i = 0; i < 4; i++) tick();
    // reset in an RD_E cycle with C pending
    set_e(0, 32'h2C, 0); tick();
    set_c(0, 32'h30, 0); rst_v = 1; tick(); tick(); rst_v = 0;
    for (int i = 0; i < 3; i++) tick();
    // E request rising during RD_C
    set_c(0, 32'h10, 0); tick();
    set_e(0, 32'h10, 0);
    for (int i = 0; i < 4; i++) tick();
    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if (!c_r && $urandom_range(0, 2) == 0) set_c(1'($urandom), 32'($urandom_range(0, 15)) << 2, $urandom);
      if (!e_r && $urandom_range(0, 3) == 0) set_e(1'($urandom), 32'($urandom_range(0, 15)) << 2, $urandom);
      rst_v = $urandom_range(0, 63) == 0;
      tick();
    end
    rst_v = 0;
    for (int k = 0; k < 4 && q.size() > 0; k++) @(negedge clk);
    #1;
    checks++;
    if (q.size() == 0) passed++;
    else $display("FAIL drain: %0d expected responses left, required 0", q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
